// File: rtl/imuldiv_mul_arbiter_if.sv
// imuldiv_mul_arbiter_if
//   Bundles the two requester ports, the two response ports and the
//   multiplier request/response ports of imuldiv_mul_arbiter.
//   slave  : the arbiter's view.
//   master : the surrounding system's view (requesters, consumers, multiplier).
interface imuldiv_mul_arbiter_if;
    // Requester 0
    logic [31:0] req0_msg_a;
    logic [31:0] req0_msg_b;
    logic [1:0]  req0_op;
    logic        req0_val;
    logic        req0_rdy;
    // Requester 1
    logic [31:0] req1_msg_a;
    logic [31:0] req1_msg_b;
    logic [1:0]  req1_op;
    logic        req1_val;
    logic        req1_rdy;
    // Responses
    logic [31:0] resp0_msg;
    logic        resp0_val;
    logic        resp0_rdy;
    logic [31:0] resp1_msg;
    logic        resp1_val;
    logic        resp1_rdy;
    // Multiplier request
    logic [31:0] mulreq_msg_a;
    logic [31:0] mulreq_msg_b;
    logic        mul_signed_a;
    logic        mul_signed_b;
    logic        mulreq_val;
    logic        mulreq_rdy;
    // Multiplier response
    logic [63:0] mulresp_msg_result;
    logic        mulresp_val;
    logic        mulresp_rdy;

    modport slave (
        input  req0_msg_a, req0_msg_b, req0_op, req0_val,
        output req0_rdy,
        input  req1_msg_a, req1_msg_b, req1_op, req1_val,
        output req1_rdy,
        output resp0_msg, resp0_val,
        input  resp0_rdy,
        output resp1_msg, resp1_val,
        input  resp1_rdy,
        output mulreq_msg_a, mulreq_msg_b, mul_signed_a, mul_signed_b, mulreq_val,
        input  mulreq_rdy,
        input  mulresp_msg_result, mulresp_val,
        output mulresp_rdy
    );

    modport master (
        output req0_msg_a, req0_msg_b, req0_op, req0_val,
        input  req0_rdy,
        output req1_msg_a, req1_msg_b, req1_op, req1_val,
        input  req1_rdy,
        input  resp0_msg, resp0_val,
        output resp0_rdy,
        input  resp1_msg, resp1_val,
        output resp1_rdy,
        input  mulreq_msg_a, mulreq_msg_b, mul_signed_a, mul_signed_b, mulreq_val,
        output mulreq_rdy,
        output mulresp_msg_result, mulresp_val,
        input  mulresp_rdy
    );
endinterface

// File: rtl/imuldiv_mul_arbiter.sv
// imuldiv_mul_arbiter
//   Shares one iterative multiplier between two requesters with round-robin
//   arbitration and a single transaction in flight. Decodes the 2-bit RISC-V
//   mul op into operand signedness and returns the selected 32-bit half.
//   Optional feature macro: IMULDIV_MUL_ARB_REUSE_EN keeps the last product
//   and answers an identical follow-up request without using the multiplier.
//
// Handshake semantics (all ports): a transfer happens on the rising clock edge
// where val and rdy are both 1. Once val is raised the payload stays stable
// until that edge; val never depends on rdy.
module imuldiv_mul_arbiter #(
    parameter logic PRIO_INIT = 1'b0
) (
    input  logic                        clk,
    input  logic                        reset,
    imuldiv_mul_arbiter_if.slave        io_bus,
    output logic [1:0]                  o_dbg_state
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_RESP  = 2'd3
    } state_t;

    state_t      r_state;
    state_t      w_next_state;

    logic        r_rr_ptr;
    logic        r_owner;
    logic [31:0] r_a;
    logic [31:0] r_b;
    logic [1:0]  r_op;
    logic [31:0] r_result;

    logic        w_any_val;
    logic        w_grant;
    logic [31:0] w_sel_a;
    logic [31:0] w_sel_b;
    logic [1:0]  w_sel_op;
    logic        w_lat_sa;
    logic        w_lat_sb;
    logic        w_hit;
    logic [31:0] w_hit_half;

    logic        w_req0_rdy;
    logic        w_req1_rdy;
    logic        w_accept;
    logic        w_mulreq_val;
    logic        w_mulresp_rdy;
    logic        w_mulresp_fire;
    logic        w_resp0_val;
    logic        w_resp1_val;
    logic        w_resp_fire;

    // Op decode: {signed_a, signed_b}. MUL's low half does not care, use unsigned.
    function automatic logic [1:0] f_decode(input logic [1:0] op);
        case (op)
            2'd1:    f_decode = 2'b11;  // MULH   s*s
            2'd2:    f_decode = 2'b10;  // MULHSU s*u
            default: f_decode = 2'b00;  // MUL, MULHU
        endcase
    endfunction

    // Grant selection: the sole valid requester, or the round-robin pointer on a tie.
    always_comb begin
        w_any_val = io_bus.req0_val | io_bus.req1_val;
        if (io_bus.req0_val && io_bus.req1_val) begin
            w_grant = r_rr_ptr;
        end else begin
            w_grant = io_bus.req1_val;
        end
        w_sel_a  = w_grant ? io_bus.req1_msg_a : io_bus.req0_msg_a;
        w_sel_b  = w_grant ? io_bus.req1_msg_b : io_bus.req0_msg_b;
        w_sel_op = w_grant ? io_bus.req1_op    : io_bus.req0_op;
    end

    assign {w_lat_sa, w_lat_sb} = f_decode(r_op);

`ifdef IMULDIV_MUL_ARB_REUSE_EN
    logic        r_hit_valid;
    logic [63:0] r_hit_prod;
    logic [31:0] r_key_a;
    logic [31:0] r_key_b;
    logic        r_key_sa;
    logic        r_key_sb;
    logic        w_sel_sa;
    logic        w_sel_sb;

    assign {w_sel_sa, w_sel_sb} = f_decode(w_sel_op);
    assign w_hit = r_hit_valid && (r_key_a == w_sel_a) && (r_key_b == w_sel_b) &&
                   ((w_sel_op == 2'd0) || ((r_key_sa == w_sel_sa) && (r_key_sb == w_sel_sb)));
    assign w_hit_half = (w_sel_op == 2'd0) ? r_hit_prod[31:0] : r_hit_prod[63:32];

    // Remember the most recent full product and the key it was computed for.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_hit_valid <= 1'b0;
            r_hit_prod  <= 64'h0;
            r_key_a     <= 32'h0;
            r_key_b     <= 32'h0;
            r_key_sa    <= 1'b0;
            r_key_sb    <= 1'b0;
        end else if (w_mulresp_fire) begin
            r_hit_valid <= 1'b1;
            r_hit_prod  <= io_bus.mulresp_msg_result;
            r_key_a     <= r_a;
            r_key_b     <= r_b;
            r_key_sa    <= w_lat_sa;
            r_key_sb    <= w_lat_sb;
        end
    end
`else
    assign w_hit      = 1'b0;
    assign w_hit_half = 32'h0;
`endif

    // FSM state register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // FSM next state and handshake outputs; requester rdy is gated by reset so
    // nothing is offered while reset is held.
    always_comb begin
        w_next_state   = r_state;
        w_req0_rdy     = 1'b0;
        w_req1_rdy     = 1'b0;
        w_accept       = 1'b0;
        w_mulreq_val   = 1'b0;
        w_mulresp_rdy  = 1'b0;
        w_mulresp_fire = 1'b0;
        w_resp0_val    = 1'b0;
        w_resp1_val    = 1'b0;
        w_resp_fire    = 1'b0;
        case (r_state)
            ST_IDLE: begin
                w_req0_rdy = reset & w_any_val & ~w_grant;
                w_req1_rdy = reset & w_any_val &  w_grant;
                w_accept   = w_req0_rdy | w_req1_rdy;
                if (w_accept) begin
                    w_next_state = w_hit ? ST_RESP : ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                w_mulreq_val = 1'b1;
                if (io_bus.mulreq_rdy) begin
                    w_next_state = ST_WAIT;
                end
            end
            ST_WAIT: begin
                w_mulresp_rdy  = 1'b1;
                w_mulresp_fire = io_bus.mulresp_val;
                if (io_bus.mulresp_val) begin
                    w_next_state = ST_RESP;
                end
            end
            ST_RESP: begin
                w_resp0_val = ~r_owner;
                w_resp1_val =  r_owner;
                w_resp_fire = r_owner ? io_bus.resp1_rdy : io_bus.resp0_rdy;
                if (w_resp_fire) begin
                    w_next_state = ST_IDLE;
                end
            end
            default: begin
                w_next_state = ST_IDLE;
            end
        endcase
    end

    // Transaction data: latch on accept, capture the result half, rotate priority on completion.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_rr_ptr <= PRIO_INIT;
            r_owner  <= 1'b0;
            r_a      <= 32'h0;
            r_b      <= 32'h0;
            r_op     <= 2'd0;
            r_result <= 32'h0;
        end else begin
            if (w_accept) begin
                r_a     <= w_sel_a;
                r_b     <= w_sel_b;
                r_op    <= w_sel_op;
                r_owner <= w_grant;
                if (w_hit) begin
                    r_result <= w_hit_half;
                end
            end
            if (w_mulresp_fire) begin
                r_result <= (r_op == 2'd0) ? io_bus.mulresp_msg_result[31:0]
                                           : io_bus.mulresp_msg_result[63:32];
            end
            if (w_resp_fire) begin
                r_rr_ptr <= ~r_owner;
            end
        end
    end

    assign io_bus.req0_rdy     = w_req0_rdy;
    assign io_bus.req1_rdy     = w_req1_rdy;
    assign io_bus.resp0_msg    = r_result;
    assign io_bus.resp0_val    = w_resp0_val;
    assign io_bus.resp1_msg    = r_result;
    assign io_bus.resp1_val    = w_resp1_val;
    assign io_bus.mulreq_msg_a = r_a;
    assign io_bus.mulreq_msg_b = r_b;
    assign io_bus.mul_signed_a = w_lat_sa;
    assign io_bus.mul_signed_b = w_lat_sb;
    assign io_bus.mulreq_val   = w_mulreq_val;
    assign io_bus.mulresp_rdy  = w_mulresp_rdy;
    assign o_dbg_state         = r_state;

endmodule

// File: tb/tb_imuldiv_mul_arbiter.sv
// tb_imuldiv_mul_arbiter
//   Drives both requesters, models the multiplier and both response
//   consumers, and scores every response against a product computed directly
//   from the op's arithmetic meaning.
`timescale 1ns/1ps
module tb_imuldiv_mul_arbiter;

    logic       clk;
    logic       reset;
    logic [1:0] dbg_state;

    imuldiv_mul_arbiter_if ifc ();

    imuldiv_mul_arbiter #(.PRIO_INIT(1'b0)) dut (
        .clk         (clk),
        .reset       (reset),
        .io_bus      (ifc.slave),
        .o_dbg_state (dbg_state)
    );

    int          n_tests;
    int          n_fail;
    logic [31:0] exp_q0[$];
    logic [31:0] exp_q1[$];
    int          acc_log[$];
    int          n_resp0;
    int          n_resp1;
    int          n_mulreq;
    logic [31:0] last_msg0;
    logic [31:0] last_msg1;
    logic        last_sa;
    logic        last_sb;
    int          force0;   // 0/1: fixed resp rdy, 2: random
    int          force1;
    bit          mul_stall;

    // ---------------- clock ----------------
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, time %0t", $time);
        $fatal(1, "watchdog");
    end

    // ---------------- checking ----------------
    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Reference: the op's arithmetic meaning in 64-bit integers.
    function automatic logic [31:0] ref_result(input logic [31:0] a, input logic [31:0] b,
                                               input logic [1:0] op);
        longint      sa, sb, ua, ub;
        logic [63:0] p;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ua = longint'({32'h0, a});
        ub = longint'({32'h0, b});
        case (op)
            2'd1:    p = sa * sb;
            2'd2:    p = sa * ub;
            default: p = ua * ub;
        endcase
        return (op == 2'd0) ? p[31:0] : p[63:32];
    endfunction

    // ---------------- drivers ----------------
    task automatic drive(input int port, input logic v, input logic [31:0] a,
                         input logic [31:0] b, input logic [1:0] op);
        if (port == 0) begin
            ifc.req0_val = v; ifc.req0_msg_a = a; ifc.req0_msg_b = b; ifc.req0_op = op;
        end else begin
            ifc.req1_val = v; ifc.req1_msg_a = a; ifc.req1_msg_b = b; ifc.req1_op = op;
        end
    endtask

    function automatic logic req_rdy(input int port);
        return (port == 0) ? ifc.req0_rdy : ifc.req1_rdy;
    endfunction

    // Call at a falling edge; returns at the falling edge after the accept edge.
    task automatic send(input int port, input logic [31:0] a, input logic [31:0] b,
                        input logic [1:0] op);
        int t;
        t = 0;
        drive(port, 1'b1, a, b, op);
        forever begin
            #1;
            if (req_rdy(port)) break;
            @(negedge clk);
            t++;
            if (t > 400) begin
                check($sformatf("req%0d_timeout", port), req_rdy(port), 1);
                drive(port, 1'b0, 32'h0, 32'h0, 2'd0);
                return;
            end
        end
        if (port == 0) exp_q0.push_back(ref_result(a, b, op));
        else           exp_q1.push_back(ref_result(a, b, op));
        acc_log.push_back(port);
        @(negedge clk);
        drive(port, 1'b0, 32'h0, 32'h0, 2'd0);
    endtask

    task automatic drain();
        int t;
        t = 0;
        while ((exp_q0.size() != 0 || exp_q1.size() != 0) && t < 300) begin
            @(negedge clk);
            t++;
        end
        if (t >= 300) check("drain_timeout", exp_q0.size() + exp_q1.size(), 0);
    endtask

    function automatic logic [31:0] pick_operand();
        case ($urandom_range(0, 6))
            0:       return 32'h0;
            1:       return 32'hFFFF_FFFF;
            2:       return 32'h8000_0000;
            3:       return 32'h7FFF_FFFF;
            4:       return 32'h0001_0000;
            default: return $urandom;
        endcase
    endfunction

    task automatic rand_txn(input int port);
        logic [31:0] a, b;
        repeat ($urandom_range(0, 3)) @(negedge clk);
        a = pick_operand();
        b = pick_operand();
        send(port, a, b, 2'($urandom_range(0, 3)));
    endtask

    // ---------------- response consumers / scoreboard ----------------
    task automatic sink_loop(input int port);
        logic v, r;
        logic [31:0] m;
        forever begin
            @(negedge clk);
            if (port == 0) ifc.resp0_rdy = (force0 == 2) ? ($urandom_range(0, 2) != 0) : force0[0];
            else           ifc.resp1_rdy = (force1 == 2) ? ($urandom_range(0, 2) != 0) : force1[0];
            #2;
            v = (port == 0) ? ifc.resp0_val : ifc.resp1_val;
            r = (port == 0) ? ifc.resp0_rdy : ifc.resp1_rdy;
            m = (port == 0) ? ifc.resp0_msg : ifc.resp1_msg;
            if (reset && v && r) begin
                if (port == 0) begin
                    n_resp0++;
                    last_msg0 = m;
                    if (exp_q0.size() == 0) check("resp0_unexpected", v, 0);
                    else                    check("resp0_msg", m, exp_q0.pop_front());
                end else begin
                    n_resp1++;
                    last_msg1 = m;
                    if (exp_q1.size() == 0) check("resp1_unexpected", v, 0);
                    else                    check("resp1_msg", m, exp_q1.pop_front());
                end
            end
        end
    endtask

    initial begin ifc.resp0_rdy = 1'b0; sink_loop(0); end
    initial begin ifc.resp1_rdy = 1'b0; sink_loop(1); end

    // ---------------- multiplier model ----------------
    initial begin : mul_model
        bit          req_hs, resp_hs, busy;
        int          lat;
        logic [31:0] ca, cb;
        logic        csa, csb;
        logic [63:0] ea, eb, prod;
        req_hs = 0; resp_hs = 0; busy = 0; lat = 0;
        ca = 0; cb = 0; csa = 0; csb = 0; prod = 0;
        ifc.mulreq_rdy = 1'b0;
        ifc.mulresp_val = 1'b0;
        ifc.mulresp_msg_result = 64'h0;
        forever begin
            @(negedge clk);
            if (!reset) begin
                busy = 0; req_hs = 0; resp_hs = 0;
                ifc.mulreq_rdy = 1'b0;
                ifc.mulresp_val = 1'b0;
            end else begin
                if (resp_hs) begin
                    ifc.mulresp_val = 1'b0;
                    busy = 0;
                end
                if (req_hs) begin
                    busy = 1;
                    lat = $urandom_range(0, 3);
                    ea = csa ? {{32{ca[31]}}, ca} : {32'h0, ca};
                    eb = csb ? {{32{cb[31]}}, cb} : {32'h0, cb};
                    prod = ea * eb;
                end
                if (busy && !ifc.mulresp_val && !mul_stall) begin
                    if (lat == 0) begin
                        ifc.mulresp_val = 1'b1;
                        ifc.mulresp_msg_result = prod;
                    end else begin
                        lat--;
                    end
                end
                ifc.mulreq_rdy = busy ? 1'b0 : 1'($urandom_range(0, 1));
            end
            #1;
            req_hs  = reset && ifc.mulreq_val && ifc.mulreq_rdy;
            resp_hs = reset && ifc.mulresp_val && ifc.mulresp_rdy;
            if (req_hs) begin
                ca = ifc.mulreq_msg_a; cb = ifc.mulreq_msg_b;
                csa = ifc.mul_signed_a; csb = ifc.mul_signed_b;
                last_sa = csa; last_sb = csb;
                n_mulreq++;
            end
        end
    end

    // ---------------- main sequence ----------------
    initial begin : main
        int          t, k;
        logic [31:0] held;
        n_tests = 0; n_fail = 0;
        n_resp0 = 0; n_resp1 = 0; n_mulreq = 0;
        last_msg0 = 0; last_msg1 = 0; last_sa = 0; last_sb = 0;
        force0 = 1; force1 = 1; mul_stall = 0;
        reset = 1'b0;
        drive(0, 1'b1, 32'h1, 32'h2, 2'd0);
        drive(1, 1'b1, 32'h3, 32'h4, 2'd1);
        repeat (3) @(negedge clk);
        #1;
        check("reset_handshakes", {ifc.req0_rdy, ifc.req1_rdy, ifc.resp0_val, ifc.resp1_val,
                                   ifc.mulreq_val, ifc.mulresp_rdy}, 6'b0);
        check("reset_resp0_msg", ifc.resp0_msg, 32'h0);
        check("reset_mulreq_a", ifc.mulreq_msg_a, 32'h0);
        @(negedge clk);
        drive(0, 1'b0, 32'h0, 32'h0, 2'd0);
        drive(1, 1'b0, 32'h0, 32'h0, 2'd0);
        reset = 1'b1;
        @(negedge clk);

        // Simultaneous requests after reset: req0 first, then req1; again req0 first.
        for (int pair = 0; pair < 2; pair++) begin
            acc_log.delete();
            fork
                send(0, $urandom, $urandom, 2'($urandom_range(0, 3)));
                send(1, $urandom, $urandom, 2'($urandom_range(0, 3)));
            join
            drain();
            check($sformatf("pair%0d_first", pair), acc_log[0], 0);
            check($sformatf("pair%0d_second", pair), acc_log[1], 1);
        end
        // A lone req0 leaves priority with req1 for the next tie.
        send(0, 32'd9, 32'd9, 2'd0);
        drain();
        acc_log.delete();
        fork
            send(0, $urandom, $urandom, 2'd3);
            send(1, $urandom, $urandom, 2'd1);
        join
        drain();
        check("pair_after_req0_first", acc_log[0], 1);
        check("pair_after_req0_second", acc_log[1], 0);

        // req0 MUL 3*5; issue happens the cycle after accept.
        k = n_resp1;
        send(0, 32'd3, 32'd5, 2'd0);
        #1;
        check("issue_after_accept", ifc.mulreq_val, 1);
        drain();
        check("mul_value", last_msg0, 32'd15);
        check("mul_signed_a", last_sa, 0);
        check("mul_signed_b", last_sb, 0);
        check("mul_no_resp1", n_resp1, k);

        // Signed variants on req1.
        send(1, 32'hFFFF_FFFE, 32'd3, 2'd1);
        drain();
        check("mulh_value", last_msg1, 32'hFFFF_FFFF);
        check("mulh_signs", {last_sa, last_sb}, 2'b11);
        send(1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 2'd3);
        drain();
        check("mulhu_value", last_msg1, 32'hFFFF_FFFE);
        check("mulhu_signs", {last_sa, last_sb}, 2'b00);
        send(1, 32'hFFFF_FFFF, 32'd2, 2'd2);
        drain();
        check("mulhsu_value", last_msg1, 32'hFFFF_FFFF);
        check("mulhsu_signs", {last_sa, last_sb}, 2'b10);

        // Backpressure on resp0 while req1 waits.
        force0 = 0;
        @(negedge clk);
        @(negedge clk);
        send(0, 32'h1234_5678, 32'h9ABC_DEF0, 2'd2);
        t = 0;
        while (t < 50) begin
            #3;
            if (ifc.resp0_val) break;
            @(negedge clk);
            t++;
        end
        check("bp_resp0_val_seen", ifc.resp0_val, 1);
        held = ifc.resp0_msg;
        fork
            begin
                @(negedge clk);
                send(1, 32'd100, 32'd200, 2'd0);
            end
            begin
                for (int i = 0; i < 10; i++) begin
                    @(negedge clk);
                    #3;
                    check("bp_resp0_val", ifc.resp0_val, 1);
                    check("bp_resp0_msg", ifc.resp0_msg, held);
                    check("bp_req1_rdy_low", ifc.req1_rdy, 0);
                end
                force0 = 1;
                @(negedge clk);
                @(negedge clk);
                #3;
                check("bp_req1_granted", ifc.req1_rdy, 1);
            end
        join
        drain();

        // Reset while waiting on the multiplier.
        mul_stall = 1;
        send(0, 32'd11, 32'd13, 2'd0);
        t = 0;
        while (t < 50) begin
            #3;
            if (ifc.mulresp_rdy) break;
            @(negedge clk);
            t++;
        end
        check("rst_reached_wait", ifc.mulresp_rdy, 1);
        @(negedge clk);
        drive(1, 1'b1, 32'd5, 32'd5, 2'd0);
        reset = 1'b0;
        #1;
        check("rst_mid_handshakes", {ifc.req0_rdy, ifc.req1_rdy, ifc.resp0_val, ifc.resp1_val,
                                     ifc.mulreq_val, ifc.mulresp_rdy}, 6'b0);
        exp_q0.delete();
        @(negedge clk);
        #1;
        check("rst_hold_handshakes", {ifc.req0_rdy, ifc.req1_rdy, ifc.resp0_val, ifc.resp1_val,
                                      ifc.mulreq_val, ifc.mulresp_rdy}, 6'b0);
        @(negedge clk);
        drive(1, 1'b0, 32'h0, 32'h0, 2'd0);
        reset = 1'b1;
        mul_stall = 0;
        @(negedge clk);
        send(0, 32'd7, 32'd6, 2'd0);
        drain();
        check("post_rst_mul", last_msg0, 32'd42);

        // Same operands twice: MULHU then MUL.
        send(0, 32'h0001_0000, 32'h0001_0000, 2'd3);
        drain();
        check("reuse_first_hi", last_msg0, 32'h1);
        k = n_mulreq;
        send(0, 32'h0001_0000, 32'h0001_0000, 2'd0);
`ifdef IMULDIV_MUL_ARB_REUSE_EN
        #3;
        check("reuse_resp_next_cycle", ifc.resp0_val, 1);
        drain();
        check("reuse_no_mulreq", n_mulreq, k);
`else
        drain();
        check("noreuse_mulreq", n_mulreq, k + 1);
`endif
        check("reuse_second_lo", last_msg0, 32'h0);

        // Randomized traffic on both ports with random response backpressure.
        force0 = 2;
        force1 = 2;
        k = n_resp0 + n_resp1;
        fork
            for (int i = 0; i < 30; i++) rand_txn(0);
            for (int i = 0; i < 30; i++) rand_txn(1);
        join
        drain();
        check("rand_resp_count", n_resp0 + n_resp1 - k, 60);

        repeat (2) @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
